// File: rtl/gb_cpu_common_pkg.sv
// Shared constants and helpers for the CPU-side bus blocks: register addresses,
// interrupt indices and the acknowledge priority mask.
package gb_cpu_common_pkg;

    localparam logic [15:0] ADDR_IF      = 16'hFF0F;
    localparam logic [15:0] ADDR_IE      = 16'hFFFF;
    localparam logic [15:0] ADDR_HRAM_LO = 16'hFF80;
    localparam logic [15:0] ADDR_HRAM_HI = 16'hFFFE;

    localparam int IRQ_W = 5;

    typedef enum logic [2:0] {
        IRQ_VBLANK,
        IRQ_STAT,
        IRQ_TIMER,
        IRQ_SERIAL,
        IRQ_JOYPAD
    } irq_idx_t;

    // One-hot mask of the lowest set bit; zero when nothing is set.
    function automatic logic [4:0] lowestSetMask5(input logic [4:0] v);
        logic [4:0] m;
        m = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (v[i]) m = 5'b00001 << i;
        end
        return m;
    endfunction

endpackage

// File: rtl/gb_hram.sv
// 127-byte high RAM: combinational read, write committed on the clock edge.
module gb_hram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:126];

    // NOTE: RAM arrays carry no reset; clearing them would forbid RAM inference
    // and software never relies on power-up HRAM contents.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/gb_interrupt_bus_responder.sv
// CPU-side responder for IF, IE and HRAM; owns the interrupt flag/enable
// registers, latches peripheral request edges and services CPU acknowledges.
module gb_interrupt_bus_responder
    import gb_cpu_common_pkg::*;
#(
    parameter bit          HRAM_EN  = 1'b1,
    parameter int unsigned IRQ_SYNC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      addr_i,
    input  logic [7:0]       data_i,
    input  logic             wr_en_i,
    input  logic             clear_interrupt_flag,
    input  logic [IRQ_W-1:0] irq_req_i,
    output logic [7:0]       data_o,
    output logic             hit_o,
    output logic [7:0]       reg_IF,
    output logic [7:0]       reg_IE,
    output logic             irq_pending_o
);

    logic [IRQ_W-1:0] if_q;
    logic [7:0]       ie_q;
    logic [IRQ_W-1:0] req_s;
    logic [IRQ_W-1:0] req_prev;

    logic             if_hit;
    logic             ie_hit;
    logic             hram_hit;
    logic [7:0]       hram_rdata;

    assign if_hit = (addr_i == ADDR_IF);
    assign ie_hit = (addr_i == ADDR_IE);

    generate
        if (IRQ_SYNC != 0) begin : g_sync
            logic [IRQ_W-1:0] sync1;
            logic [IRQ_W-1:0] sync2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1 <= '0;
                    sync2 <= '0;
                end else begin
                    sync1 <= irq_req_i;
                    sync2 <= sync1;
                end
            end

            assign req_s = sync2;
        end else begin : g_nosync
            assign req_s = irq_req_i;
        end
    endgenerate

    generate
        if (HRAM_EN) begin : g_hram
            logic hram_we;

            assign hram_hit = (addr_i >= ADDR_HRAM_LO) && (addr_i <= ADDR_HRAM_HI);
            assign hram_we  = wr_en_i && hram_hit;

            gb_hram u_hram (
                .clk   (clk),
                .we    (hram_we),
                .addr  (addr_i[6:0]),
                .wdata (data_i),
                .rdata (hram_rdata)
            );
        end else begin : g_no_hram
            assign hram_hit   = 1'b0;
            assign hram_rdata = 8'hFF;
        end
    endgenerate

    // Order within one cycle: CPU write, then acknowledge, then request set, so
    // a fresh edge always survives a same-cycle clear or zero write.
    logic [IRQ_W-1:0] set_mask;
    logic [IRQ_W-1:0] clr_mask;
    logic [IRQ_W-1:0] if_wr;
    logic [IRQ_W-1:0] if_next;
    logic [7:0]       ie_next;

    always_comb begin
        set_mask = req_s & ~req_prev;
        clr_mask = clear_interrupt_flag ? lowestSetMask5(if_q) : '0;
        if_wr    = (wr_en_i && if_hit) ? data_i[IRQ_W-1:0] : if_q;
        if_next  = (if_wr & ~clr_mask) | set_mask;
        ie_next  = (wr_en_i && ie_hit) ? data_i : ie_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_q     <= '0;
            ie_q     <= 8'h00;
            req_prev <= '0;
        end else begin
            if_q     <= if_next;
            ie_q     <= ie_next;
            req_prev <= req_s;
        end
    end

    assign reg_IF        = {3'b111, if_q};
    assign reg_IE        = ie_q;
    assign irq_pending_o = |(if_q & ie_q[IRQ_W-1:0]);

    // NOTE: defaults first, so every path assigns both outputs and no latch forms.
    always_comb begin
        hit_o  = if_hit || ie_hit || hram_hit;
        data_o = 8'hFF;
        if (if_hit)        data_o = {3'b111, if_q};
        else if (ie_hit)   data_o = ie_q;
        else if (hram_hit) data_o = hram_rdata;
    end

endmodule

// File: tb/tb_gb_interrupt_bus_responder.sv
// Self-checking bench: directed scenarios plus randomized bus/interrupt traffic
// compared against a cycle-level model of the register and HRAM behaviour.
module tb_gb_interrupt_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr_i = 16'h0000;
    logic [7:0]  data_i = 8'h00;
    logic        wr_en_i = 1'b0;
    logic        clear_interrupt_flag = 1'b0;
    logic [4:0]  irq_req_i = 5'b0;
    logic [7:0]  data_o;
    logic        hit_o;
    logic [7:0]  reg_IF;
    logic [7:0]  reg_IE;
    logic        irq_pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [4:0] if_m;
    logic [7:0] ie_m;
    logic [4:0] prev_m;
    logic [7:0] hram_m [0:126];

    always #5 clk = ~clk;

    gb_interrupt_bus_responder #(.HRAM_EN(1'b1), .IRQ_SYNC(0)) dut (
        .clk                  (clk),
        .reset                (reset),
        .addr_i               (addr_i),
        .data_i               (data_i),
        .wr_en_i              (wr_en_i),
        .clear_interrupt_flag (clear_interrupt_flag),
        .irq_req_i            (irq_req_i),
        .data_o               (data_o),
        .hit_o                (hit_o),
        .reg_IF               (reg_IF),
        .reg_IE               (reg_IE),
        .irq_pending_o        (irq_pending_o)
    );

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w,
                         input logic c, input logic [4:0] irq);
        addr_i = a; data_i = d; wr_en_i = w; clear_interrupt_flag = c; irq_req_i = irq;
    endtask

    task automatic model_reset();
        if_m = 5'b0; ie_m = 8'h00; prev_m = 5'b0;
    endtask

    // Advance one clock: model computes from the spec rules, DUT clocks, then
    // the model commits. Returns at posedge+1.
    task automatic tick();
        logic [4:0] nif;
        logic [4:0] clr;
        int idx;
        nif = (wr_en_i && addr_i == 16'hFF0F) ? data_i[4:0] : if_m;
        clr = 5'b0;
        if (clear_interrupt_flag) begin
            for (int i = 0; i < 5; i++) begin
                if (if_m[i] && clr == 5'b0) clr[i] = 1'b1;
            end
        end
        nif = (nif & ~clr) | (irq_req_i & ~prev_m);
        @(posedge clk);
        #1;
        if (wr_en_i && addr_i == 16'hFFFF) ie_m = data_i;
        if (wr_en_i && addr_i >= 16'hFF80 && addr_i <= 16'hFFFE) begin
            idx = int'(addr_i) - 'hFF80;
            hram_m[idx] = data_i;
        end
        if_m   = nif;
        prev_m = irq_req_i;
    endtask

    task automatic exp_read(input logic [15:0] a, output logic h, output logic [7:0] d);
        h = 1'b1;
        if (a == 16'hFF0F)                        d = {3'b111, if_m};
        else if (a == 16'hFFFF)                   d = ie_m;
        else if (a >= 16'hFF80 && a <= 16'hFFFE)  d = hram_m[int'(a) - 'hFF80];
        else begin h = 1'b0; d = 8'hFF; end
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        drive(a, d, 1'b1, 1'b0, irq_req_i);
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (reg_IF !== 8'hE0 || reg_IE !== 8'h00 || irq_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: IF=%h IE=%h pend=%b, want E0 00 0", reg_IF, reg_IE, irq_pending_o);
        end
        model_reset();
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_bus();
        write(16'hFFFF, 8'h3C);
        write(16'hFF0F, 8'h1B);
        addr_i = 16'hFFFF; #1;
        n_checks++;
        if (hit_o !== 1'b1 || data_o !== 8'h3C) begin
            n_fail++; $display("FAIL bus_ie_read: hit=%b data=%h, want 1 3C", hit_o, data_o);
        end
        addr_i = 16'hFF0F; #1;
        n_checks++;
        if (hit_o !== 1'b1 || data_o !== 8'hFB) begin
            n_fail++; $display("FAIL bus_if_read: hit=%b data=%h, want 1 FB", hit_o, data_o);
        end
        addr_i = 16'hC000; #1;
        n_checks++;
        if (hit_o !== 1'b0 || data_o !== 8'hFF) begin
            n_fail++; $display("FAIL bus_miss_read: hit=%b data=%h, want 0 FF", hit_o, data_o);
        end
        addr_i = 16'hFF7F; #1;
        n_checks++;
        if (hit_o !== 1'b0 || data_o !== 8'hFF) begin
            n_fail++; $display("FAIL bus_below_hram: hit=%b data=%h, want 0 FF", hit_o, data_o);
        end
    endtask

    task automatic test_hram();
        logic [7:0] v;
        for (int i = 0; i < 127; i++) begin
            v = 8'($urandom);
            write(16'hFF80 + 16'(i), v);
        end
        for (int k = 0; k < 20; k++) begin
            int i;
            logic       eh;
            logic [7:0] ed;
            i = (k == 0) ? 0 : (k == 1) ? 126 : int'($urandom_range(0, 126));
            addr_i = 16'hFF80 + 16'(i); #1;
            exp_read(addr_i, eh, ed);
            n_checks++;
            if (hit_o !== eh || data_o !== ed) begin
                n_fail++;
                $display("FAIL hram_read[%0d]: hit=%b data=%h, want %b %h", i, hit_o, data_o, eh, ed);
            end
        end
    endtask

    task automatic test_edge();
        write(16'hFF0F, 8'h00);
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 5'b00100);
        for (int c = 0; c < 5; c++) begin
            clear_interrupt_flag = (c == 1);
            tick();
            n_checks++;
            if (reg_IF !== ((c == 0) ? 8'hE4 : 8'hE0)) begin
                n_fail++;
                $display("FAIL edge_cycle%0d: IF=%h, want %h", c, reg_IF, (c == 0) ? 8'hE4 : 8'hE0);
            end
        end
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 5'b00000);
        tick();
    endtask

    task automatic test_priority();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hF4, 8'hF0, 8'hE0, 8'hE0};
        write(16'hFF0F, 8'hF6);
        n_checks++;
        if (reg_IF !== 8'hF6) begin
            n_fail++; $display("FAIL prio_setup: IF=%h, want F6", reg_IF);
        end
        for (int k = 0; k < 4; k++) begin
            clear_interrupt_flag = 1'b1;
            tick();
            n_checks++;
            if (reg_IF !== exp_seq[k]) begin
                n_fail++; $display("FAIL prio_ack%0d: IF=%h, want %h", k, reg_IF, exp_seq[k]);
            end
        end
        clear_interrupt_flag = 1'b0;
    endtask

    task automatic test_collision();
        write(16'hFF0F, 8'h01);
        drive(16'hFF0F, 8'h00, 1'b1, 1'b1, 5'b00001);
        tick();
        n_checks++;
        if (reg_IF !== 8'hE1) begin
            n_fail++; $display("FAIL collision: IF=%h, want E1", reg_IF);
        end
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 5'b00000);
        tick();
    endtask

    task automatic test_pending();
        write(16'hFF0F, 8'h00);
        write(16'hFFFF, 8'h04);
        irq_req_i = 5'b00100;
        tick();
        n_checks++;
        if (irq_pending_o !== 1'b1 || reg_IF !== 8'hE4) begin
            n_fail++; $display("FAIL pending_set: pend=%b IF=%h, want 1 E4", irq_pending_o, reg_IF);
        end
        write(16'hFFFF, 8'h00);
        n_checks++;
        if (irq_pending_o !== 1'b0 || reg_IF !== 8'hE4) begin
            n_fail++; $display("FAIL pending_clear: pend=%b IF=%h, want 0 E4", irq_pending_o, reg_IF);
        end
        irq_req_i = 5'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        write(16'hFF80, 8'hA5);
        write(16'hFF0F, 8'hFF);
        write(16'hFFFF, 8'h1F);
        n_checks++;
        if (reg_IF !== 8'hFF || reg_IE !== 8'h1F) begin
            n_fail++; $display("FAIL midrun_setup: IF=%h IE=%h, want FF 1F", reg_IF, reg_IE);
        end
        irq_req_i = 5'b00001;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (reg_IF !== 8'hE0 || reg_IE !== 8'h00 || irq_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: IF=%h IE=%h pend=%b, want E0 00 0", reg_IF, reg_IE, irq_pending_o);
        end
        model_reset();
        @(negedge clk) reset = 1'b0;
        addr_i = 16'hFF80; #1;
        n_checks++;
        if (hit_o !== 1'b1 || data_o !== 8'hA5) begin
            n_fail++; $display("FAIL hram_retained: hit=%b data=%h, want 1 A5", hit_o, data_o);
        end
        tick();
        n_checks++;
        if (reg_IF !== 8'hE1) begin
            n_fail++; $display("FAIL held_req_after_reset: IF=%h, want E1", reg_IF);
        end
        tick();
        n_checks++;
        if (reg_IF !== 8'hE1) begin
            n_fail++; $display("FAIL held_req_once: IF=%h, want E1", reg_IF);
        end
        irq_req_i = 5'b0;
    endtask

    task automatic test_random();
        logic       eh;
        logic [7:0] ed;
        logic [15:0] a;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'hFF0F;
                1:       a = 16'hFFFF;
                2:       a = 16'hFF80 + 16'($urandom_range(0, 126));
                default: a = 16'($urandom);
            endcase
            drive(a, 8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0) ? 5'($urandom) : irq_req_i);
            #1;
            exp_read(addr_i, eh, ed);
            n_checks++;
            if (hit_o !== eh || data_o !== ed) begin
                n_fail++;
                $display("FAIL rand_read c%0d addr=%h: hit=%b data=%h, want %b %h", c, addr_i, hit_o, data_o, eh, ed);
            end
            tick();
            n_checks++;
            if (reg_IF !== {3'b111, if_m} || reg_IE !== ie_m || irq_pending_o !== |(if_m & ie_m[4:0])) begin
                n_fail++;
                $display("FAIL rand_regs c%0d: IF=%h IE=%h pend=%b, want %h %h %b", c, reg_IF, reg_IE,
                         irq_pending_o, {3'b111, if_m}, ie_m, |(if_m & ie_m[4:0]));
            end
        end
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 5'b0);
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bus();
        test_hram();
        test_edge();
        test_priority();
        test_collision();
        test_pending();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
